// File: rtl/dmem_pkg.sv
// Shared types for the data-memory master: op codes, FSM states and
// small decode helpers used by both the FSM and the lane aligner.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } dmem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_DATA  = 3'd2,
    ST_WR       = 3'd3,
    ST_RESP     = 3'd4
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } dmem_size_e;

  function automatic logic OP_IS_STORE(dmem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic dmem_size_e OP_SIZE(dmem_op_e op);
    case (op)
      OP_LW, OP_SW:          return SZ_WORD;
      OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
      default:               return SZ_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: extracts and extends load lanes, and merges
// sub-word store data into the previously read word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  dmem_op_e    op,
  input  logic [1:0]  offset,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] mask;

  always_comb begin
    sh   = {offset, 3'b000};
    lane = 16'(old_word >> sh);
    mask = (OP_SIZE(op) == SZ_HALF) ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
    if (OP_SIZE(op) == SZ_WORD) begin
      merged = wdata;
    end else begin
      merged = (old_word & ~mask) | ((wdata << sh) & mask);
    end
    case (op)
      OP_LH:   load_data = {{16{lane[15]}}, lane};
      OP_LHU:  load_data = {16'h0000, lane};
      OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_data = {24'h000000, lane[7:0]};
      default: load_data = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_master.sv
// Data-memory initiator: takes CPU load/store requests, drives a single-port
// word memory with 1-cycle read latency, and does sub-word stores by RMW.
module dmem_master
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_dout
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready is high only in IDLE; resp_valid is high only in RESP and the
  // response fields hold until resp_ready completes the transfer.

  dmem_state_e       state_q, state_d;
  dmem_op_e          req_op_e, op_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] wdata_q, merged_q, rdata_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              err_q;
  logic              accept, req_err;
  logic [DATA_W-1:0] load_data, merged;

  assign req_op_e = dmem_op_e'(req_op);
  assign accept   = req_valid && (state_q == ST_IDLE);

  // Out-of-range or misaligned requests never touch the memory.
  assign req_err = (|req_addr[31:ADDR_W+2])
                || ((OP_SIZE(req_op_e) == SZ_HALF) && req_addr[0])
                || ((OP_SIZE(req_op_e) == SZ_WORD) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                state_d = ST_RESP;
          else if (req_op_e == OP_SW) state_d = ST_WR;
          else                        state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_DATA;
      ST_RD_DATA:  state_d = OP_IS_STORE(op_q) ? ST_WR : ST_RESP;
      ST_WR:       state_d = ST_RESP;
      ST_RESP:     if (resp_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_LW;
      off_q    <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      waddr_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q    <= req_op_e;
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
      waddr_q <= req_addr[ADDR_W+1:2];
      err_q   <= req_err;
      rdata_q <= '0;
    end else if (state_q == ST_RD_DATA) begin
      merged_q <= merged;
      if (!OP_IS_STORE(op_q)) rdata_q <= load_data;
    end
  end

  dmem_lane_align u_align (
    .op        (op_q),
    .offset    (off_q),
    .old_word  (mem_dout),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // mem_rw decodes the state register directly so an async reset drops it at once.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_rw     = (state_q == ST_WR);
  assign mem_addr   = waddr_q;
  assign mem_din    = (op_q == OP_SW) ? wdata_q : merged_q;

endmodule
